// File: rtl/plru_state_tracker.sv
// plru_state_tracker: per-set tree pseudo-LRU bits with a 2-stage update pipeline,
// a bypassed registered read port and a one-set-per-cycle clear sequencer.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   upd_valid_i       update request present
//   upd_ready_o       update may be accepted this cycle (IDLE and no clear_req)
//   upd_set_i         set to update
//   upd_way_i         way accessed
//   upd_demote_i      0 = touch (make MRU), 1 = demote (make next victim)
//   rd_valid_i        read request
//   rd_set_i          set to read
//   rd_bits_o         tree bits of the requested set (held while no read)
//   rd_bits_valid_o   rd_bits_o was loaded by the read sampled at the last edge
//   clear_req_i       start a clear sequence (pulse)
//   clear_busy_o      clear sequence in progress
//   clear_done_o      one-cycle pulse after the last set is cleared
module plru_state_tracker #(
  parameter int ASSOCIATIVITY = 8,
  parameter int NUM_SETS      = 16,
  localparam int WAY_W        = $clog2(ASSOCIATIVITY),
  localparam int SET_W        = $clog2(NUM_SETS),
  localparam int NW           = ASSOCIATIVITY - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [SET_W-1:0] upd_set_i,
  input  logic [WAY_W-1:0] upd_way_i,
  input  logic             upd_demote_i,
  input  logic             rd_valid_i,
  input  logic [SET_W-1:0] rd_set_i,
  output logic [NW-1:0]    rd_bits_o,
  output logic             rd_bits_valid_o,
  input  logic             clear_req_i,
  output logic             clear_busy_o,
  output logic             clear_done_o
);
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic stg_vld_q, stg_vld_d;
  logic [SET_W-1:0] stg_set_q, stg_set_d;
  logic [NW-1:0] stg_bits_q, stg_bits_d;
  logic [NW-1:0] rd_bits_q, rd_bits_d;
  logic rd_vld_q, rd_vld_d;
  logic [NW-1:0] mem_q [NUM_SETS];
  logic clr_wr, upd_acc;
  logic [NW-1:0] base, rd_byp;

  // Walk the root-to-leaf path of way w; each node on the path points away from w
  // (touch) or towards w (demote). Nodes off the path keep their value.
  function automatic logic [NW-1:0] plru_apply(input logic [NW-1:0] b,
                                               input logic [WAY_W-1:0] w,
                                               input logic dem);
    logic [NW-1:0] r;
    int a;
    r = b;
    a = 0;
    for (int k = 0; k < WAY_W; k++) begin
      for (int n = 0; n < NW; n++)
        if (n == a) r[n] = dem ? w[WAY_W-1-k] : ~w[WAY_W-1-k];
      a = 2 * a + 1 + int'(w[WAY_W-1-k]);
    end
    return r;
  endfunction

  assign upd_ready_o     = (state_q == IDLE) && !clear_req_i;
  assign clear_busy_o    = (state_q == CLEAR);
  assign clear_done_o    = done_q;
  assign rd_bits_o       = rd_bits_q;
  assign rd_bits_valid_o = rd_vld_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr_wr  = 1'b0;
    if (state_q == IDLE) begin
      if (clear_req_i) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    end else begin
      clr_wr = 1'b1;
      // The counter parks on the last set instead of wrapping.
      if (cnt_q == SET_W'(NUM_SETS - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    upd_acc    = upd_valid_i && upd_ready_o;
    // A same-set update committing this edge is the true current state of the set.
    base       = (stg_vld_q && stg_set_q == upd_set_i) ? stg_bits_q : mem_q[upd_set_i];
    stg_vld_d  = upd_acc;
    stg_set_d  = upd_acc ? upd_set_i : stg_set_q;
    stg_bits_d = upd_acc ? plru_apply(base, upd_way_i, upd_demote_i) : stg_bits_q;
    // Reads see whatever the array will hold right after this edge.
    rd_byp     = (stg_vld_q && stg_set_q == rd_set_i) ? stg_bits_q :
                 (clr_wr && cnt_q == rd_set_i) ? '0 : mem_q[rd_set_i];
    rd_bits_d  = rd_valid_i ? rd_byp : rd_bits_q;
    rd_vld_d   = rd_valid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      stg_vld_q  <= 1'b0;
      stg_set_q  <= '0;
      stg_bits_q <= '0;
      rd_bits_q  <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      stg_vld_q  <= stg_vld_d;
      stg_set_q  <= stg_set_d;
      stg_bits_q <= stg_bits_d;
      rd_bits_q  <= rd_bits_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // Stage writes and clear writes never coincide: no update is accepted while clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) mem_q[i] <= '0;
    end else begin
      if (stg_vld_q) mem_q[stg_set_q] <= stg_bits_q;
      if (clr_wr) mem_q[cnt_q] <= '0;
    end
  end
endmodule

// File: tb/tb_plru_state_tracker.sv
module tb_plru_state_tracker;
  localparam int NS = 16;
  localparam int WW = 3;
  localparam int SW = 4;
  localparam int NW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic upd_valid_i = 1'b0, upd_demote_i = 1'b0, rd_valid_i = 1'b0, clear_req_i = 1'b0;
  logic [SW-1:0] upd_set_i = '0, rd_set_i = '0;
  logic [WW-1:0] upd_way_i = '0;
  logic upd_ready_o, rd_bits_valid_o, clear_busy_o, clear_done_o;
  logic [NW-1:0] rd_bits_o;

  plru_state_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_set_i(upd_set_i), .upd_way_i(upd_way_i), .upd_demote_i(upd_demote_i),
    .rd_valid_i(rd_valid_i), .rd_set_i(rd_set_i),
    .rd_bits_o(rd_bits_o), .rd_bits_valid_o(rd_bits_valid_o),
    .clear_req_i(clear_req_i), .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  logic [NW-1:0] mdl [NS];
  bit busy_m;
  int clr_idx;
  logic [NW-1:0] exp_rd;
  bit rdy_obs;

  // Level l of the tree holds nodes (2^l - 1) .. (2^(l+1) - 2); way w passes through
  // the node selected by its top l bits.
  function automatic logic [NW-1:0] ref_apply(input logic [NW-1:0] b, input int way, input bit dem);
    for (int l = 0; l < WW; l++) begin
      int node = (1 << l) - 1 + (way >> (WW - l));
      bit d = ((way >> (WW - 1 - l)) & 1) != 0;
      b[node] = dem ? d : !d;
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mdl[i] = '0;
    busy_m = 0;
    clr_idx = 0;
  endtask

  task automatic do_reset();
    upd_valid_i = 0; rd_valid_i = 0; clear_req_i = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle; the model applies accepted updates at once, since every later
  // read must see them while a read at the accepting edge must not.
  task automatic step(input bit uv, input int us, input int uw, input bit ud,
                      input bit rv, input int rs, input bit cr);
    bit acc;
    upd_valid_i = uv; upd_set_i = SW'(us); upd_way_i = WW'(uw); upd_demote_i = ud;
    rd_valid_i = rv; rd_set_i = SW'(rs); clear_req_i = cr;
    acc = uv && !busy_m && !cr;
    @(negedge clk);
    rdy_obs = upd_ready_o;
    @(posedge clk);
    if (rv) exp_rd = mdl[rs];
    if (busy_m) begin
      mdl[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == NS) busy_m = 0;
    end else if (cr) begin
      busy_m = 1;
      clr_idx = 0;
    end else if (acc) begin
      mdl[us] = ref_apply(mdl[us], uw, ud);
    end
    #1;
    upd_valid_i = 0; rd_valid_i = 0; clear_req_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_bits_o !== 7'h00 || rd_bits_valid_o !== 1'b0 || clear_busy_o !== 1'b0 ||
        clear_done_o !== 1'b0 || upd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs got bits=%h v=%b busy=%b done=%b rdy=%b exp 00 0 0 0 1",
               rd_bits_o, rd_bits_valid_o, clear_busy_o, clear_done_o, upd_ready_o);
    end
    for (int s = 0; s < NS; s++) begin
      step(0, 0, 0, 0, 1, s, 0);
      checks++;
      if (rd_bits_o !== 7'h00 || rd_bits_valid_o !== 1'b1) begin
        fails++;
        $display("FAIL reset_read set=%0d got=%h v=%b exp=00 v=1", s, rd_bits_o, rd_bits_valid_o);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rd_bits_valid_o !== 1'b0 || rd_bits_o !== 7'h00) begin
      fails++;
      $display("FAIL read_idle got v=%b bits=%h exp v=0 bits=00", rd_bits_valid_o, rd_bits_o);
    end
  endtask

  task automatic test_touch();
    do_reset();
    step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    checks++;
    if (rd_bits_o !== 7'h0B) begin
      fails++;
      $display("FAIL touch_w0 got=%h exp=0b", rd_bits_o);
    end
    step(1, 3, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    checks++;
    if (rd_bits_o !== 7'h2E) begin
      fails++;
      $display("FAIL touch_w4 got=%h exp=2e", rd_bits_o);
    end
  endtask

  task automatic test_demote();
    do_reset();
    step(1, 5, 6, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0);
    checks++;
    if (rd_bits_o !== 7'h05) begin
      fails++;
      $display("FAIL demote_w6 got=%h exp=05", rd_bits_o);
    end
    step(0, 0, 0, 0, 1, 4, 0);
    checks++;
    if (rd_bits_o !== 7'h00) begin
      fails++;
      $display("FAIL demote_other_set got=%h exp=00", rd_bits_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 7, 0, 0, 0, 0, 0);
    step(1, 7, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0);
    checks++;
    if (rd_bits_o !== 7'h2E) begin
      fails++;
      $display("FAIL forward_b2b got=%h exp=2e", rd_bits_o);
    end
    step(1, 7, 2, 0, 1, 7, 0);
    checks++;
    if (rd_bits_o !== 7'h2E) begin
      fails++;
      $display("FAIL same_cycle_read got=%h exp=2e", rd_bits_o);
    end
    step(0, 0, 0, 0, 1, 7, 0);
    checks++;
    if (rd_bits_o !== 7'h3D) begin
      fails++;
      $display("FAIL next_cycle_read got=%h exp=3d", rd_bits_o);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rd_bits_o !== 7'h3D) begin
      fails++;
      $display("FAIL read_hold got=%h exp=3d", rd_bits_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit uv = $urandom_range(0, 3) != 0;
      bit rv = $urandom_range(0, 1) != 0;
      int rs = $urandom_range(0, 3);
      step(uv, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1) != 0, rv, rs, 0);
      checks++;
      if (rd_bits_valid_o !== rv || (rv && rd_bits_o !== exp_rd)) begin
        fails++;
        $display("FAIL random_read i=%0d set=%0d got=%h v=%b exp=%h v=%b", i, rs, rd_bits_o,
                 rd_bits_valid_o, exp_rd, rv);
      end
    end
  endtask

  task automatic test_clear();
    int n_busy = 0, n_done = 0;
    for (int i = 0; i < 12; i++) step(1, i, $urandom_range(0, 7), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 11, 0);
    checks++;
    if (rd_bits_o !== exp_rd || exp_rd === 7'h00) begin
      fails++;
      $display("FAIL clear_populate got=%h exp=%h (nonzero)", rd_bits_o, exp_rd);
    end
    step(1, 2, 5, 0, 0, 0, 1);
    checks++;
    if (rdy_obs !== 1'b0) begin
      fails++;
      $display("FAIL clear_req_ready got=%b exp=0", rdy_obs);
    end
    for (int i = 0; i < 40; i++) begin
      if (clear_busy_o === 1'b1) n_busy++;
      if (clear_done_o === 1'b1) n_done++;
      step(i < 10, 15, 3, 0, 0, 0, i == 4);
      if (i < 10) begin
        checks++;
        if (rdy_obs !== 1'b0) begin
          fails++;
          $display("FAIL busy_ready i=%0d got=%b exp=0", i, rdy_obs);
        end
      end
    end
    checks++;
    if (n_busy != 16 || n_done != 1) begin
      fails++;
      $display("FAIL clear_timing busy_cycles=%0d done_pulses=%0d exp 16 and 1", n_busy, n_done);
    end
    for (int s = 0; s < NS; s++) begin
      step(0, 0, 0, 0, 1, s, 0);
      checks++;
      if (rd_bits_o !== 7'h00) begin
        fails++;
        $display("FAIL clear_read set=%0d got=%h exp=00", s, rd_bits_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1, i, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 1, 9, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (rd_bits_o !== 7'h00 || rd_bits_valid_o !== 1'b0 || clear_busy_o !== 1'b0 ||
        clear_done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_clear got bits=%h v=%b busy=%b done=%b exp all 0",
               rd_bits_o, rd_bits_valid_o, clear_busy_o, clear_done_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1, 3, i, 0, 0, 0, 0);
    step(1, 8, 5, 0, 1, 3, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (rd_bits_o !== 7'h00 || rd_bits_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_update got bits=%h v=%b exp 00 0", rd_bits_o, rd_bits_valid_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    checks++;
    if (upd_ready_o !== 1'b1 || clear_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got rdy=%b busy=%b exp 1 0", upd_ready_o, clear_busy_o);
    end
    for (int s = 0; s < NS; s++) begin
      step(0, 0, 0, 0, 1, s, 0);
      checks++;
      if (rd_bits_o !== 7'h00) begin
        fails++;
        $display("FAIL post_reset_read set=%0d got=%h exp=00", s, rd_bits_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_touch();
    test_demote();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
